// File: rtl/phys_reg_file.sv
// Physical register file with a per-register ready scoreboard.
// Writeback sets ready; rename allocation clears it. Allocation wins over a
// write to the same register in the same cycle, and the highest-index write
// port wins among colliding writes. Register 0 reads as zero/ready.
// Optional macro PHYS_REG_FILE_BYPASS_EN forwards same-cycle writes to reads.
module phys_reg_file #(
  parameter int DATA_WIDTH  = 64,
  parameter int PHYS_COUNT  = 64,
  parameter int ADDR_WIDTH  = $clog2(PHYS_COUNT),
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4,
  parameter int ALLOC_PORTS = 2
) (
  input  logic                                     clk,
  input  logic                                     async_rst_n,
  input  logic                                     clk_en,
  input  logic [WRITE_PORTS-1:0]                   wr_en,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic [ALLOC_PORTS-1:0]                   alloc_en,
  input  logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]   alloc_addr,
  input  logic [READ_PORTS-1:0]                    rd_en,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]    rd_addr,
  output logic [READ_PORTS-1:0]                    rd_valid,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]    rd_data,
  output logic [READ_PORTS-1:0]                    rd_ready
);

  // Addresses at or above this limit do not name a register.
  localparam logic [ADDR_WIDTH:0] PHYS_LIMIT = PHYS_COUNT[ADDR_WIDTH:0];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < PHYS_LIMIT);
  endfunction

  // Writable means in range and not the hard-wired zero register.
  function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] a);
    return addr_ok(a) && (a != '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem_reg  [PHYS_COUNT];
  logic [DATA_WIDTH-1:0] mem_next [PHYS_COUNT];
  logic [PHYS_COUNT-1:0] ready_reg;
  logic [PHYS_COUNT-1:0] ready_next;

  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data_next;
  logic [READ_PORTS-1:0]                 rd_ready_next;

  // Next storage/scoreboard: writes in ascending port order (last wins), then allocs.
  always_comb begin
    mem_next   = mem_reg;
    ready_next = ready_reg;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wr_en[p] && addr_writable(wr_addr[p])) begin
        mem_next[wr_addr[p]]   = wr_data[p];
        ready_next[wr_addr[p]] = 1'b1;
      end
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (alloc_en[a] && addr_writable(alloc_addr[a])) begin
        ready_next[alloc_addr[a]] = 1'b0;
      end
    end
  end

  // Storage and scoreboard state; reset clears data and marks everything ready.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int r = 0; r < PHYS_COUNT; r++) begin
        mem_reg[r] <= '0;
      end
      ready_reg <= '1;
    end else if (clk_en) begin
      mem_reg   <= mem_next;
      ready_reg <= ready_next;
    end
  end

  // Per-port read select; out-of-range addresses read as data 0, not ready.
  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic rd_ok;
    assign rd_ok = addr_ok(rd_addr[gi]);
`ifdef PHYS_REG_FILE_BYPASS_EN
    assign rd_data_next[gi]  = rd_ok ? mem_next[rd_addr[gi]]   : '0;
    assign rd_ready_next[gi] = rd_ok ? ready_next[rd_addr[gi]] : 1'b0;
`else
    assign rd_data_next[gi]  = rd_ok ? mem_reg[rd_addr[gi]]    : '0;
    assign rd_ready_next[gi] = rd_ok ? ready_reg[rd_addr[gi]]  : 1'b0;
`endif
  end

  // Registered read results; idle ports drop valid but hold their last data.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
      rd_ready <= '0;
    end else if (clk_en) begin
      rd_valid <= rd_en;
      for (int k = 0; k < READ_PORTS; k++) begin
        if (rd_en[k]) begin
          rd_data[k]  <= rd_data_next[k];
          rd_ready[k] <= rd_ready_next[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_file.sv
// Scoreboard bench for phys_reg_file (PHYS_COUNT=48 so out-of-range
// addresses are reachable). Honors PHYS_REG_FILE_BYPASS_EN like the DUT.
module tb_phys_reg_file;
  localparam int DW = 64;
  localparam int PC = 48;
  localparam int AW = 6;
  localparam int WP = 2;
  localparam int RP = 4;
  localparam int AP = 2;

  logic clk = 1'b0;
  logic async_rst_n;
  logic clk_en;
  logic [WP-1:0]         wr_en;
  logic [WP-1:0][AW-1:0] wr_addr;
  logic [WP-1:0][DW-1:0] wr_data;
  logic [AP-1:0]         alloc_en;
  logic [AP-1:0][AW-1:0] alloc_addr;
  logic [RP-1:0]         rd_en;
  logic [RP-1:0][AW-1:0] rd_addr;
  logic [RP-1:0]         rd_valid;
  logic [RP-1:0][DW-1:0] rd_data;
  logic [RP-1:0]         rd_ready;

  phys_reg_file #(
    .DATA_WIDTH(DW), .PHYS_COUNT(PC), .ADDR_WIDTH(AW),
    .WRITE_PORTS(WP), .READ_PORTS(RP), .ALLOC_PORTS(AP)
  ) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [DW-1:0] model_mem [PC];
  logic          model_rdy [PC];
  exp_t          last_out  [RP];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < PC; r++) begin
      model_mem[r] = '0;
      model_rdy[r] = 1'b1;
    end
    for (int k = 0; k < RP; k++) begin
      last_out[k].v = 1'b0;
      last_out[k].d = '0;
      last_out[k].r = 1'b0;
    end
    exp_q.delete();
  endtask

  function automatic exp_t model_read(input logic [AW-1:0] a);
    exp_t e;
    e.v = 1'b1;
    if (int'(a) >= PC) begin
      e.d = '0;
      e.r = 1'b0;
    end else begin
      e.d = model_mem[a];
      e.r = model_rdy[a];
    end
    return e;
  endfunction

  task automatic clear_inputs();
    clk_en = 1'b1;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  // One clock: predict outputs, push, update model, clock, pop and compare.
  task automatic do_cycle(input string tag);
    exp_t pre [RP];
    exp_t post[RP];
    exp_t e;
    for (int k = 0; k < RP; k++) pre[k] = model_read(rd_addr[k]);
    if (clk_en) begin
      // highest port first; a lower port only writes if no higher port hit the same address
      for (int p = WP - 1; p >= 0; p--) begin
        logic shadowed;
        shadowed = 1'b0;
        for (int q = p + 1; q < WP; q++)
          if (wr_en[q] && wr_addr[q] == wr_addr[p]) shadowed = 1'b1;
        if (wr_en[p] && !shadowed && wr_addr[p] != 0 && int'(wr_addr[p]) < PC) begin
          model_mem[wr_addr[p]] = wr_data[p];
          model_rdy[wr_addr[p]] = 1'b1;
        end
      end
      for (int a = 0; a < AP; a++)
        if (alloc_en[a] && alloc_addr[a] != 0 && int'(alloc_addr[a]) < PC)
          model_rdy[alloc_addr[a]] = 1'b0;
    end
    for (int k = 0; k < RP; k++) post[k] = model_read(rd_addr[k]);
    for (int k = 0; k < RP; k++) begin
      if (!clk_en) begin
        e = last_out[k];
      end else if (rd_en[k]) begin
`ifdef PHYS_REG_FILE_BYPASS_EN
        e = post[k];
`else
        e = pre[k];
`endif
      end else begin
        e = last_out[k];
        e.v = 1'b0;
      end
      last_out[k] = e;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < RP; k++) begin
      if (exp_q.size() == 0) begin
        check_val($sformatf("%s_qempty%0d", tag, k), 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("%s_rd%0d_valid", tag, k), DW'(rd_valid[k]), DW'(e.v));
        check_val($sformatf("%s_rd%0d_data", tag, k), rd_data[k], e.d);
        check_val($sformatf("%s_rd%0d_ready", tag, k), DW'(rd_ready[k]), DW'(e.r));
      end
    end
    $display("[TB] %s: valid=%b ready=%b data0=%h", tag, rd_valid, rd_ready, rd_data[0]);
    clear_inputs();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_valid"}, DW'(rd_valid), '0);
    check_val({tag, "_ready"}, DW'(rd_ready), '0);
    for (int k = 0; k < RP; k++)
      check_val($sformatf("%s_data%0d", tag, k), rd_data[k], '0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    async_rst_n = 1'b0;
    #2;
    check_outputs_zero("rst_initial");
    @(posedge clk); #1;
    async_rst_n = 1'b1;

    // first read after reset
    rd_en[0] = 1'b1; rd_addr[0] = 6'd5;
    do_cycle("rst_read5");

    // alloc 7, read between, write 7 two cycles after alloc, read again
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd7;
    do_cycle("alloc7");
    rd_en[1] = 1'b1; rd_addr[1] = 6'd7;
    do_cycle("read7_pending");
    wr_en[0] = 1'b1; wr_addr[0] = 6'd7; wr_data[0] = 64'hDEAD;
    do_cycle("write7");
    rd_en[2] = 1'b1; rd_addr[2] = 6'd7;
    do_cycle("read7_done");

    // write-write collision, then alloc+write collision
    wr_en = 2'b11; wr_addr[0] = 6'd9; wr_addr[1] = 6'd9;
    wr_data[0] = 64'h11; wr_data[1] = 64'h22;
    do_cycle("ww9");
    rd_en[0] = 1'b1; rd_addr[0] = 6'd9;
    do_cycle("read9_ww");
    wr_en[1] = 1'b1; wr_addr[1] = 6'd9; wr_data[1] = 64'h33;
    alloc_en[1] = 1'b1; alloc_addr[1] = 6'd9;
    do_cycle("aw9");
    rd_en[3] = 1'b1; rd_addr[3] = 6'd9;
    do_cycle("read9_aw");

    // same-cycle write and read of 12
    wr_en[0] = 1'b1; wr_addr[0] = 6'd12; wr_data[0] = 64'hABC;
    rd_en[0] = 1'b1; rd_addr[0] = 6'd12;
    do_cycle("bypass12");
    rd_en[0] = 1'b1; rd_addr[0] = 6'd12;
    do_cycle("read12");

    // register 0 is immutable
    wr_en[0] = 1'b1; wr_addr[0] = 6'd0; wr_data[0] = 64'hFF;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd0;
    do_cycle("write0");
    rd_en[1] = 1'b1; rd_addr[1] = 6'd0;
    do_cycle("read0");

    // out of range and top register boundary
    wr_en = 2'b11; wr_addr[0] = 6'd50; wr_data[0] = 64'h55;
    wr_addr[1] = 6'd47; wr_data[1] = 64'h47;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd48;
    do_cycle("write_oor");
    rd_en = 4'b1111; rd_addr[0] = 6'd50; rd_addr[1] = 6'd47;
    rd_addr[2] = 6'd48; rd_addr[3] = 6'd63;
    do_cycle("read_oor");

    // clk_en low: write ignored, outputs hold
    clk_en = 1'b0;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd3; wr_data[0] = 64'h3333;
    rd_en = 4'b0011; rd_addr[0] = 6'd3; rd_addr[1] = 6'd9;
    do_cycle("clken_off");
    rd_en[0] = 1'b1; rd_addr[0] = 6'd3;
    do_cycle("read3");

    // random traffic
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < WP; p++) begin
        wr_en[p] = 1'($urandom_range(0, 1));
        wr_addr[p] = AW'($urandom_range(0, 15));
        wr_data[p] = {32'($urandom), 32'($urandom)};
      end
      for (int a = 0; a < AP; a++) begin
        alloc_en[a] = ($urandom_range(0, 3) == 0);
        alloc_addr[a] = AW'($urandom_range(0, 15));
      end
      for (int k = 0; k < RP; k++) begin
        rd_en[k] = 1'($urandom_range(0, 1));
        rd_addr[k] = AW'($urandom_range(0, 15));
      end
      clk_en = ($urandom_range(0, 7) != 0);
      do_cycle($sformatf("rand%0d", n));
    end

    // make outputs nonzero, then reset mid-cycle
    rd_en = 4'b1111; rd_addr[0] = 6'd7; rd_addr[1] = 6'd9;
    rd_addr[2] = 6'd12; rd_addr[3] = 6'd47;
    do_cycle("pre_rst");
    rd_en = 4'b1111;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 64'h5555;
    #3;
    async_rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    check_outputs_zero("rst_held");
    async_rst_n = 1'b1;
    rd_en[0] = 1'b1; rd_addr[0] = 6'd5;
    rd_en[1] = 1'b1; rd_addr[1] = 6'd7;
    do_cycle("rst_read5_again");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
